// File: rtl/blink_pkg.sv
// Shared definitions for the blink path: monitor FSM encoding and
// compile-time helpers for deriving cycle counts from frequencies.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    // Minimum number of bits needed to hold values 0..value-1 (at least 1).
    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < value) begin
            bits = bits + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

    // Nominal period of a divided clock, in board-clock cycles.
    function automatic int unsigned derived_period(input longint unsigned board_hz,
                                                   input longint unsigned target_hz);
        return 32'(board_hz / target_hz);
    endfunction

    // Allowed period deviation in cycles for an integer percentage.
    function automatic int unsigned tolerance_cycles(input longint unsigned period_cycles,
                                                     input longint unsigned percent);
        return 32'((period_cycles * percent) / 64'd100);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus one history flop,
// producing a single-cycle rising-edge strobe in the clk domain.
module edge_sync
    import blink_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync3_q, sync3_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            sync3_q <= sync3_d;
        end
    end

    assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/blink_monitor.sv
// Measures the rising-to-rising period of an external square wave and
// reports tolerance, lock and timeout status against an expected frequency.
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned EXPECTED_FREQUENCY_IN_HZ    = 1,
    parameter int unsigned TOLERANCE_PERCENT           = 5,
    parameter int unsigned LOCK_COUNT                  = 4,
    localparam int unsigned EXP_PERIOD = derived_period(BOARD_CLOCK_FREQUENCY_IN_HZ,
                                                        EXPECTED_FREQUENCY_IN_HZ),
    localparam int unsigned TOL        = tolerance_cycles(EXP_PERIOD, TOLERANCE_PERCENT),
    localparam int unsigned TIMEOUT    = 2 * EXP_PERIOD,
    localparam int unsigned CNT_W      = clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blink_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_tolerance,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned GOOD_W     = clog2(LOCK_COUNT + 1);
    localparam int unsigned PERIOD_MIN = EXP_PERIOD - TOL;
    localparam int unsigned PERIOD_MAX = EXP_PERIOD + TOL;

    logic              rise;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              valid_q, valid_d;
    logic              intol_q, intol_d;
    logic              locked_q, locked_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  meas;
    logic              meas_ok;
    logic              cnt_expiring;

    edge_sync u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (blink_in),
        .rise     (rise)
    );

    // Counter holds cycles elapsed since the last rise, so the period includes the rise cycle.
    assign meas         = cnt_q + CNT_W'(1);
    assign meas_ok      = (meas >= CNT_W'(PERIOD_MIN)) && (meas <= CNT_W'(PERIOD_MAX));
    assign cnt_expiring = (cnt_q >= CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
        good_d    = good_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        intol_d   = intol_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (rise) begin
            cnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            MEASURE, LOCKED: begin
                if (rise) begin
                    period_d = meas;
                    valid_d  = 1'b1;
                    intol_d  = meas_ok;
                    if (!meas_ok) begin
                        good_d   = '0;
                        locked_d = 1'b0;
                        state_d  = MEASURE;
                    end else if (state_q == MEASURE) begin
                        if (good_q + GOOD_W'(1) >= GOOD_W'(LOCK_COUNT)) begin
                            good_d   = GOOD_W'(LOCK_COUNT);
                            locked_d = 1'b1;
                            state_d  = LOCKED;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end else if (cnt_expiring) begin
                    // A rise on the expiring cycle wins; only a silent line times out.
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            good_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            intol_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            intol_q   <= intol_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign in_tolerance = intol_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Randomized scoreboard bench for blink_monitor: an edge-time reference model
// queues expected events, and a monitor compares them as the DUT reports.
module tb_blink_monitor;

    localparam int EXP     = 100;
    localparam int TOLC    = 5;
    localparam int TMO     = 200;
    localparam int LOCK_N  = 4;
    localparam int LAT     = 2;

    localparam int K_VALID  = 0;
    localparam int K_TO_SET = 1;
    localparam int K_TO_CLR = 2;

    typedef struct {
        int kind;
        int due;
        int per;
        bit tol;
        bit lck;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       blink_in;
    logic [7:0] period;
    logic       period_valid;
    logic       in_tolerance;
    logic       locked;
    logic       timeout;

    blink_monitor #(
        .BOARD_CLOCK_FREQUENCY_IN_HZ (1000),
        .EXPECTED_FREQUENCY_IN_HZ    (10),
        .TOLERANCE_PERCENT           (5),
        .LOCK_COUNT                  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blink_in     (blink_in),
        .period       (period),
        .period_valid (period_valid),
        .in_tolerance (in_tolerance),
        .locked       (locked),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ev_t q[$];
    int  total  = 0;
    int  passed = 0;
    int  cyc    = 0;
    bit  rst_seen = 1'b0;

    // Reference model state, expressed in terms of sampled edge times.
    bit  armed   = 1'b0;
    bit  prev_s  = 1'b0;
    int  last_t  = 0;
    int  streak  = 0;
    bit  m_lock  = 1'b0;
    bit  m_to    = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        total = total + 1;
        if (got == exp) passed = passed + 1;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(posedge clk) begin
        ev_t e;
        bit  edge_s;
        int  per;
        cyc      = cyc + 1;
        rst_seen = !rst;
        if (!rst) begin
            while (q.size() > 0 && q[q.size()-1].due >= cyc) void'(q.pop_back());
            armed  = 1'b0;
            prev_s = 1'b0;
            streak = 0;
            m_lock = 1'b0;
            m_to   = 1'b0;
        end else begin
            edge_s = blink_in && !prev_s;
            prev_s = blink_in;
            if (edge_s) begin
                if (armed) begin
                    per = cyc - last_t;
                    e.kind = K_VALID;
                    e.due  = cyc + LAT;
                    e.per  = per;
                    e.tol  = (per >= EXP - TOLC) && (per <= EXP + TOLC);
                    if (e.tol) begin
                        streak = streak + 1;
                        if (streak >= LOCK_N) m_lock = 1'b1;
                    end else begin
                        streak = 0;
                        m_lock = 1'b0;
                    end
                    e.lck = m_lock;
                    q.push_back(e);
                end else begin
                    if (m_to) begin
                        e.kind = K_TO_CLR; e.due = cyc + LAT; e.per = 0; e.tol = 0; e.lck = 0;
                        q.push_back(e);
                    end
                    m_to  = 1'b0;
                    armed = 1'b1;
                end
                last_t = cyc;
            end else if (armed && (cyc - last_t) == TMO) begin
                armed  = 1'b0;
                streak = 0;
                m_lock = 1'b0;
                m_to   = 1'b1;
                e.kind = K_TO_SET; e.due = cyc + LAT; e.per = 0; e.tol = 0; e.lck = 0;
                q.push_back(e);
            end
        end
    end

    // Monitor: samples 1 time unit after the active edge.
    bit prev_to = 1'b0;
    always @(posedge clk) begin
        bit ok;
        ev_t e;
        #1;
        if (rst_seen) begin
            chk("rst_period", period, 0);
            chk("rst_valid", period_valid, 0);
            chk("rst_in_tolerance", in_tolerance, 0);
            chk("rst_locked", locked, 0);
            chk("rst_timeout", timeout, 0);
        end
        while (q.size() > 0 && q[0].due < cyc) begin
            chk("event_on_time", cyc, q[0].due);
            void'(q.pop_front());
        end
        if (period_valid) begin
            ok = (q.size() > 0) && (q[0].kind == K_VALID);
            chk("valid_expected", ok, 1);
            if (ok) begin
                e = q.pop_front();
                chk("valid_latency", cyc, e.due);
                chk("period", period, e.per);
                chk("in_tolerance", in_tolerance, e.tol);
                chk("locked", locked, e.lck);
            end
        end
        if (timeout !== prev_to) begin
            ok = (q.size() > 0) && (q[0].kind == (timeout ? K_TO_SET : K_TO_CLR));
            chk(timeout ? "timeout_set_expected" : "timeout_clr_expected", ok, 1);
            if (ok) begin
                e = q.pop_front();
                chk("timeout_latency", cyc, e.due);
                chk("timeout_locked", locked, e.lck);
            end
        end
        prev_to = timeout;
    end

    task automatic pulse(input int len, input int hi);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            blink_in = (i < hi);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            blink_in = 1'b0;
        end
    endtask

    initial begin
        int len;
        int r;
        rst      = 1'b0;
        blink_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            blink_in = ~blink_in;
        end
        @(negedge clk);
        rst      = 1'b1;
        blink_in = 1'b0;
        idle(10);

        for (int i = 0; i < 6; i++) pulse(100, 50);
        pulse(106, 53);
        pulse(105, 52);
        for (int i = 0; i < 6; i++) pulse(100, $urandom_range(1, 99));
        idle(250);
        pulse(100, 50);
        for (int i = 0; i < 6; i++) pulse(100, 50);
        pulse(40, 20);
        @(negedge clk);
        rst      = 1'b0;
        blink_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(30);
        for (int i = 0; i < 3; i++) pulse(100, 50);

        for (int i = 0; i < 5; i++) pulse(100, 1);
        pulse(200, 1);
        pulse(100, 1);
        pulse(100, 1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      len = $urandom_range(190, 260);
            else if (r == 1) len = $urandom_range(2, 60);
            else             len = $urandom_range(92, 110);
            pulse(len, $urandom_range(1, len - 1));
        end
        idle(250);
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
